hit_window_start_stop_generator: RTL and testbench

- Parametrised, multi-mode successor to the slow start/stop generator in the hit_statistics utilities.
- Produces one-cycle start/stop pulses that bracket counting windows of programmable length for downstream hit counters.
- Supports single-shot or repeated windows with a programmable gap, a window-count limit, and status/progress outputs.
- Runs entirely in the 40 MHz domain.

---
 rtl/hit_stat_pkg.sv | 18 +
 rtl/hit_down_counter.sv | 34 +++
 rtl/hit_window_start_stop_generator.sv | 165 ++++++++++++++++
 tb/tb_hit_window_start_stop_generator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_stat_pkg.sv
// Shared definitions for the hit-statistics window generators.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and mode constants used by
// hit_window_start_stop_generator.
package hit_stat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_REPEAT = 1'b1;

endpackage

// File: rtl/hit_down_counter.sv
// Loadable down-counter with a zero flag, used for window and gap timing.
// Latency: load/decrement take effect at the next clk40M edge; zero follows cnt combinationally.
// Backpressure: none; load wins over dec, and dec holds at zero instead of wrapping.
//
// Ports:
//   clk40M, rst      clock and asynchronous active-high reset
//   load, load_val   load cnt with load_val
//   dec              decrement cnt by one (ignored when cnt is already 0)
//   cnt, zero        current count and cnt==0 flag
module hit_down_counter #(
  parameter int W = 20
) (
  input  logic         clk40M,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hit_window_start_stop_generator.sv
// Generates start/stop pulses bracketing programmable counting windows (single or repeated).
// Latency: start appears one cycle after an accepted trigger; stop one cycle after the last window cycle.
// Backpressure: none; triggers arriving while busy or with enable low are dropped.
//
// Ports:
//   clk40M, rst                 40 MHz clock, asynchronous active-high reset
//   enable                      level; low aborts a run or keeps the block idle
//   trigger                     one-cycle run request (IDLE, enable high, not busy)
//   mode                        0 = single window, 1 = repeated windows
//   window_len, gap_len         window / stop-to-start spacing in cycles (0 acts as 1)
//   num_windows                 windows per repeated run (0 = until disabled)
//   start, stop                 one-cycle pulses opening/closing each window
//   window_active               high on every cycle of an open window
//   busy                        high from the first start through the closing stop
//   windows_done                saturating count of windows closed in this/last run
//   done                        one-cycle pulse alongside the final stop of a normal run
module hit_window_start_stop_generator
  import hit_stat_pkg::*;
#(
  parameter int WIN_W = 20,
  parameter int GAP_W = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk40M,
  input  logic             rst,
  input  logic             enable,
  input  logic             trigger,
  input  logic             mode,
  input  logic [WIN_W-1:0] window_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [CNT_W-1:0] num_windows,
  output logic             start,
  output logic             stop,
  output logic             window_active,
  output logic             busy,
  output logic [CNT_W-1:0] windows_done,
  output logic             done
);

  state_t           state;
  logic             cfg_mode;
  logic [WIN_W-1:0] cfg_win_m1;
  logic [GAP_W-1:0] cfg_gap_m1;
  logic [CNT_W-1:0] cfg_num;

  logic [WIN_W-1:0] win_m1_in;
  logic [GAP_W-1:0] gap_m1_in;
  logic             accept;
  logic [CNT_W-1:0] done_inc;
  logic             run_end;

  logic             win_load, win_dec, win_zero;
  logic [WIN_W-1:0] win_val, win_cnt;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_cnt;

  // Counters hold "cycles remaining after this one", so a zero length behaves as one.
  assign win_m1_in = (window_len == '0) ? '0 : window_len - WIN_W'(1);
  assign gap_m1_in = (gap_len == '0) ? '0 : gap_len - GAP_W'(1);

  // busy is still high on the closing stop cycle although state is already IDLE,
  // so a trigger there is treated as arriving while busy and dropped.
  assign accept = (state == IDLE) && !busy && trigger && enable;

  assign done_inc = (&windows_done) ? windows_done : windows_done + CNT_W'(1);
  assign run_end  = (cfg_mode == MODE_SINGLE) || ((cfg_num != '0) && (done_inc == cfg_num));

  // The first window length comes straight from the inputs on the trigger edge,
  // every later one from the latched copy.
  assign win_load = accept || ((state == GAP) && enable && gap_zero);
  assign win_val  = (state == IDLE) ? win_m1_in : cfg_win_m1;
  assign win_dec  = (state == OPEN);
  assign gap_load = (state == OPEN) && enable && win_zero;
  assign gap_dec  = (state == GAP);

  hit_down_counter #(.W(WIN_W)) u_win_cnt (
    .clk40M   (clk40M),
    .rst      (rst),
    .load     (win_load),
    .load_val (win_val),
    .dec      (win_dec),
    .cnt      (win_cnt),
    .zero     (win_zero)
  );

  hit_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk40M   (clk40M),
    .rst      (rst),
    .load     (gap_load),
    .load_val (cfg_gap_m1),
    .dec      (gap_dec),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk40M or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cfg_mode      <= MODE_SINGLE;
      cfg_win_m1    <= '0;
      cfg_gap_m1    <= '0;
      cfg_num       <= '0;
      start         <= 1'b0;
      stop          <= 1'b0;
      window_active <= 1'b0;
      busy          <= 1'b0;
      windows_done  <= '0;
      done          <= 1'b0;
    end else begin
      start <= 1'b0;
      stop  <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= accept;
          if (accept) begin
            state         <= OPEN;
            start         <= 1'b1;
            window_active <= 1'b1;
            windows_done  <= '0;
            cfg_mode      <= mode;
            cfg_win_m1    <= win_m1_in;
            cfg_gap_m1    <= gap_m1_in;
            cfg_num       <= num_windows;
          end
        end
        OPEN: begin
          if (!enable) begin
            // Abort: the partial window still gets its stop and is counted.
            stop          <= 1'b1;
            window_active <= 1'b0;
            windows_done  <= done_inc;
            state         <= IDLE;
          end else if (win_zero) begin
            stop          <= 1'b1;
            window_active <= 1'b0;
            windows_done  <= done_inc;
            if (run_end) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_zero) begin
            start         <= 1'b1;
            window_active <= 1'b1;
            state         <= OPEN;
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          window_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_window_start_stop_generator.sv
`timescale 1ns/1ps
// Bench for hit_window_start_stop_generator: per-cycle comparison against a
// schedule-based model plus hand-computed pulse timings for each scenario.
module tb_hit_window_start_stop_generator;

  localparam int WW  = 20;
  localparam int GW  = 20;
  localparam int CW  = 4;
  localparam int SAT = 15;
  localparam int BIG = 32'h3fffffff;

  logic          clk40M = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          trigger = 1'b0;
  logic          mode = 1'b0;
  logic [WW-1:0] window_len = '0;
  logic [GW-1:0] gap_len = '0;
  logic [CW-1:0] num_windows = '0;
  logic          start, stop, window_active, busy, done;
  logic [CW-1:0] windows_done;

  always #12.5 clk40M = ~clk40M;

  hit_window_start_stop_generator #(.WIN_W(WW), .GAP_W(GW), .CNT_W(CW)) dut (
    .clk40M        (clk40M),
    .rst           (rst),
    .enable        (enable),
    .trigger       (trigger),
    .mode          (mode),
    .window_len    (window_len),
    .gap_len       (gap_len),
    .num_windows   (num_windows),
    .start         (start),
    .stop          (stop),
    .window_active (window_active),
    .busy          (busy),
    .windows_done  (windows_done),
    .done          (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_trig = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  // ---------------- model: window schedule from arithmetic ----------------
  bit m_run = 0, m_abort = 0;
  int s0 = 0, mL = 1, mG = 1, m_lim = 0, m_last = 0, m_wd = 0;
  bit e_start = 0, e_stop = 0, e_wa = 0, e_busy = 0, e_done = 0;
  int e_wd = 0;

  always @(posedge clk40M) begin
    bit was_busy;
    int off, per, r;
    cyc++;
    if (rst) begin
      m_run = 0; m_abort = 0; m_wd = 0;
    end else begin
      was_busy = m_run;
      if (m_run && (cyc - 1) == m_last) begin
        m_run = 0; m_abort = 0;
      end
      if (m_run && !enable) begin
        // enable dropped during cycle cyc-1: inside a window gives a closing stop
        if (((cyc - 1 - s0) % (mL + mG)) < mL) begin
          m_abort = 1; m_last = cyc; m_wd = sat(m_wd + 1);
        end else begin
          m_run = 0;
        end
      end else if (!was_busy && trigger && enable) begin
        m_run   = 1; m_abort = 0; s0 = cyc; m_wd = 0;
        mL      = (int'(window_len) == 0) ? 1 : int'(window_len);
        mG      = (int'(gap_len) == 0) ? 1 : int'(gap_len);
        m_lim   = (mode == 1'b0) ? 1 : int'(num_windows);
        m_last  = (m_lim == 0) ? BIG : s0 + (m_lim - 1) * (mL + mG) + mL;
      end
    end
    {e_start, e_stop, e_wa, e_busy, e_done} = '0;
    if (rst) begin
      e_wd = 0;
    end else if (!m_run) begin
      e_wd = m_wd;
    end else if (m_abort) begin
      e_stop = 1; e_busy = 1; e_wd = m_wd;
    end else begin
      off     = cyc - s0;
      per     = mL + mG;
      r       = off % per;
      e_start = (r == 0);
      e_wa    = (r < mL);
      e_stop  = (r == mL);
      e_done  = e_stop && (cyc == m_last);
      e_busy  = 1;
      m_wd    = sat((off >= mL) ? (off - mL) / per + 1 : 0);
      e_wd    = m_wd;
    end
  end

  always @(negedge clk40M) begin
    if (!rst && cyc > 0) begin
      chk("start", int'(start), int'(e_start));
      chk("stop", int'(stop), int'(e_stop));
      chk("window_active", int'(window_active), int'(e_wa));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("windows_done", int'(windows_done), e_wd);
    end
  end

  // ---------------- pulse logs relative to the trigger cycle ----------------
  int logs [3][32];
  int lcnt [3];
  int busy_last = -1;

  function automatic int at(input int k, input int i);
    return (i < lcnt[k]) ? logs[k][i] : -1;
  endfunction

  task automatic clear_logs();
    for (int k = 0; k < 3; k++) lcnt[k] = 0;
    busy_last = -1;
  endtask

  always @(negedge clk40M) begin
    if (!rst) begin
      if (start) begin if (lcnt[0] < 32) logs[0][lcnt[0]] = cyc - t_trig; lcnt[0]++; end
      if (stop)  begin if (lcnt[1] < 32) logs[1][lcnt[1]] = cyc - t_trig; lcnt[1]++; end
      if (done)  begin if (lcnt[2] < 32) logs[2][lcnt[2]] = cyc - t_trig; lcnt[2]++; end
      if (busy) busy_last = cyc - t_trig;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk40M);
    #1;
  endtask

  // Presents a one-cycle trigger with the given configuration; returns in cycle T+1.
  task automatic run(input bit md, input int wl, input int gl, input int nw);
    mode        = md;
    window_len  = WW'(wl);
    gap_len     = GW'(gl);
    num_windows = CW'(nw);
    enable      = 1'b1;
    clear_logs();
    t_trig  = cyc;
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_stop"}, int'(stop), 0);
    chk({tag, "_wa"}, int'(window_active), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_wd"}, int'(windows_done), 0);
  endtask

  initial begin
    int sp;
    clear_logs();
    #2 rst = 1'b1;
    #3 chk_idle_outputs("reset");
    tick(2);
    rst = 1'b0;
    tick(3);

    // single shot, L=5
    run(1'b0, 5, 3, 0);
    tick(10);
    chk("single_start", at(0, 0), 1);
    chk("single_nstart", lcnt[0], 1);
    chk("single_stop", at(1, 0), 6);
    chk("single_done", at(2, 0), 6);
    chk("single_busy_last", busy_last, 6);
    chk("single_wd", int'(windows_done), 1);

    // repeated, L=3 G=2, 3 windows
    run(1'b1, 3, 2, 3);
    tick(20);
    chk("rep_start0", at(0, 0), 1);
    chk("rep_start1", at(0, 1), 6);
    chk("rep_start2", at(0, 2), 11);
    chk("rep_nstart", lcnt[0], 3);
    chk("rep_stop0", at(1, 0), 4);
    chk("rep_stop1", at(1, 1), 9);
    chk("rep_stop2", at(1, 2), 14);
    chk("rep_done", at(2, 0), 14);
    chk("rep_ndone", lcnt[2], 1);
    chk("rep_wd", int'(windows_done), 3);

    // zero lengths act as one
    run(1'b1, 0, 0, 2);
    tick(8);
    chk("zero_start0", at(0, 0), 1);
    chk("zero_stop0", at(1, 0), 2);
    chk("zero_start1", at(0, 1), 3);
    chk("zero_stop1", at(1, 1), 4);
    chk("zero_done", at(2, 0), 4);
    chk("zero_wd", int'(windows_done), 2);

    // abort inside a window: enable low during T+4
    run(1'b1, 10, 4, 0);
    tick(3);
    enable = 1'b0;
    tick(4);
    chk("abort_open_stop", at(1, 0), 5);
    chk("abort_open_nstop", lcnt[1], 1);
    chk("abort_open_ndone", lcnt[2], 0);
    chk("abort_open_busy_last", busy_last, 5);
    chk("abort_open_wd", int'(windows_done), 1);
    enable = 1'b1;
    tick(2);

    // abort inside the gap: stop at T+3, enable low during T+5
    run(1'b1, 2, 5, 0);
    tick(4);
    enable = 1'b0;
    tick(6);
    chk("abort_gap_nstop", lcnt[1], 1);
    chk("abort_gap_nstart", lcnt[0], 1);
    chk("abort_gap_busy_last", busy_last, 5);
    enable = 1'b1;
    tick(2);

    // trigger during OPEN, with changed config, is ignored
    run(1'b0, 6, 1, 0);
    tick(1);
    trigger    = 1'b1;
    window_len = WW'(2);
    mode       = 1'b1;
    tick(1);
    trigger = 1'b0;
    tick(8);
    chk("ign_nstart", lcnt[0], 1);
    chk("ign_stop", at(1, 0), 7);
    chk("ign_done", at(2, 0), 7);

    // trigger with enable low
    enable = 1'b0;
    clear_logs();
    t_trig  = cyc;
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
    tick(5);
    chk("dis_nstart", lcnt[0], 0);
    chk("dis_busy_last", busy_last, -1);
    enable = 1'b1;
    tick(2);

    // saturation: unlimited run of L=1 G=1 windows
    run(1'b1, 1, 1, 0);
    tick(44);
    chk("sat_wd", int'(windows_done), SAT);
    chk("sat_starts_continue", int'(lcnt[0] >= 20), 1);

    // asynchronous reset in the middle of a window (L=4 for a wide target)
    run(1'b1, 4, 2, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk40M);
      if (window_active) break;
    end
    chk("rst_window_open", int'(window_active), 1);
    sp = lcnt[1];
    #3 rst = 1'b1;
    #1 chk_idle_outputs("rst_mid");
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("rst_no_stop", lcnt[1], sp);
    chk("rst_idle_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
